// File: rtl/sram_responder.sv
// sram_responder: async-SRAM-style slave with a fixed read latency and a shared tristate data bus.
// Define SRAM_BYTE_LANE_EN to honour the UB/LB byte strobes on reads and writes.
module sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        Busy,
  output logic        AddrErr
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE} state_t;
  localparam state_t START_ST = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [19:0] lat_addr, lat_addr_n;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic [15:0] rd_word;
  logic rd_req, wr, same_addr, start, hi_err, drive;
  assign rd_req    = !CE && !OE && WE;
  assign wr        = !CE && !WE;
  assign same_addr = ADDR == lat_addr;
  assign start     = rd_req && (state == IDLE || !same_addr);
  assign hi_err    = |(ADDR >> DEPTH_LOG2);
  assign drive     = state == RD_DRIVE && rd_req && same_addr;
  assign rd_word   = mem[lat_addr[DEPTH_LOG2-1:0]];
  assign Busy      = state == RD_WAIT;
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_addr_n = lat_addr;
    if (!rd_req) begin
      state_n = IDLE;
      cnt_n   = 3'd0;
    end else if (start) begin
      state_n    = START_ST;
      cnt_n      = 3'(READ_LAT - 1);
      lat_addr_n = ADDR;
    end else if (state == RD_WAIT) begin
      cnt_n   = cnt - 3'd1;
      state_n = (cnt == 3'd1) ? RD_DRIVE : RD_WAIT;
    end
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      lat_addr <= 20'd0;
      AddrErr  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat_addr <= lat_addr_n;
      AddrErr  <= (start || wr) && hi_err;
    end
  end
`ifdef SRAM_BYTE_LANE_EN
  always_ff @(posedge Clk) begin
    if (wr && !Reset) begin
      if (!UB) mem[ADDR[DEPTH_LOG2-1:0]][15:8] <= Data[15:8];
      if (!LB) mem[ADDR[DEPTH_LOG2-1:0]][7:0] <= Data[7:0];
    end
  end
  assign Data[15:8] = (drive && !UB) ? rd_word[15:8] : 8'bz;
  assign Data[7:0]  = (drive && !LB) ? rd_word[7:0] : 8'bz;
`else
  logic unused_lanes;
  assign unused_lanes = UB ^ LB;
  always_ff @(posedge Clk) begin
    if (wr && !Reset) mem[ADDR[DEPTH_LOG2-1:0]] <= Data;
  end
  assign Data = drive ? rd_word : 16'bz;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vector table, reset/address-change sequences and a randomized run
// checked against an edge-level behavioural model of the responder.
module tb_sram_responder;
  localparam int DL  = 10;
  localparam int LAT = 2;
`ifdef SRAM_BYTE_LANE_EN
  localparam logic [15:0] R30 = 16'hBE34;
`else
  localparam logic [15:0] R30 = 16'h1234;
`endif
  logic Clk = 0, Reset = 1, CE = 1, UB = 1, LB = 1, OE = 1, WE = 1, drv = 0;
  logic [19:0] ADDR = 0;
  logic [15:0] wd = 0;
  logic Busy, AddrErr;
  tri1 [15:0] Data;
  assign Data = drv ? wd : 16'bz;
  int n_chk = 0, n_pass = 0;
  always #5 Clk = ~Clk;
  sram_responder #(.DEPTH_LOG2(DL), .READ_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR), .Data(Data), .Busy(Busy), .AddrErr(AddrErr)
  );
  // Reference model: tracks how many edges the current read has been held at one address.
  logic [15:0] mem_m [1024];
  bit held = 0, err_m = 0;
  int age = 0;
  logic [19:0] req_addr = 0;
  wire rd_m = !CE && !OE && WE;
  wire wr_m = !CE && !WE;
  wire hi_m = ADDR[19:DL] != 0;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      held = 0;
      age = 0;
      err_m = 0;
    end else begin
      err_m = (wr_m || (rd_m && !(held && ADDR == req_addr))) && hi_m;
      if (wr_m) begin
`ifdef SRAM_BYTE_LANE_EN
        if (!UB) mem_m[ADDR[9:0]][15:8] = wd[15:8];
        if (!LB) mem_m[ADDR[9:0]][7:0] = wd[7:0];
`else
        mem_m[ADDR[9:0]] = wd;
`endif
      end
      if (!rd_m) held = 0;
      else if (held && ADDR == req_addr) age++;
      else begin
        held = 1;
        age = 1;
        req_addr = ADDR;
      end
    end
  end
  function automatic logic [15:0] exp_data();
    logic [15:0] w;
    if (drv) return wd;
    if (!(rd_m && held && ADDR == req_addr && age >= LAT)) return 16'hFFFF;
    w = mem_m[ADDR[9:0]];
`ifdef SRAM_BYTE_LANE_EN
    return {UB ? 8'hFF : w[15:8], LB ? 8'hFF : w[7:0]};
`else
    return w;
`endif
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask
  task automatic set_in(input logic ce, oe, we, ub, lb, input logic [19:0] a,
                        input logic [15:0] w, input logic d);
    @(posedge Clk);
    #1;
    CE = ce; OE = oe; WE = we; UB = ub; LB = lb; ADDR = a; wd = w; drv = d;
    #1;
  endtask
  typedef struct {
    logic ce, oe, we, ub, lb;
    logic [19:0] a;
    logic [15:0] w;
    logic d;
    logic [15:0] ed;
    logic eb, ee;
  } vec_t;
  function automatic vec_t v(logic ce, oe, we, ub, lb, logic [19:0] a, logic [15:0] w,
                             logic d, logic [15:0] ed, logic eb, ee);
    v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb; v.a = a; v.w = w; v.d = d;
    v.ed = ed; v.eb = eb; v.ee = ee;
  endfunction
  vec_t tv [20];
  initial begin
    tv[0]  = v(0, 1, 0, 0, 0, 20'h010, 16'hBEEF, 1, 16'hBEEF, 0, 0);
    tv[1]  = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 0, 0);
    tv[2]  = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 1, 0);
    tv[3]  = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hBEEF, 0, 0);
    tv[4]  = v(1, 1, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 0, 0);
    tv[5]  = v(0, 0, 1, 0, 0, 20'h410, 16'h0, 0, 16'hFFFF, 0, 0);
    tv[6]  = v(0, 0, 1, 0, 0, 20'h410, 16'h0, 0, 16'hFFFF, 1, 1);
    tv[7]  = v(0, 0, 1, 0, 0, 20'h410, 16'h0, 0, 16'hBEEF, 0, 0);
    tv[8]  = v(0, 1, 0, 1, 0, 20'h010, 16'h1234, 1, 16'h1234, 0, 0);
    tv[9]  = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 0, 0);
    tv[10] = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 1, 0);
    tv[11] = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, R30, 0, 0);
    tv[12] = v(0, 0, 0, 0, 0, 20'h010, 16'h5A5A, 1, 16'h5A5A, 0, 0);
    tv[13] = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 0, 0);
    tv[14] = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'hFFFF, 1, 0);
    tv[15] = v(0, 0, 1, 0, 0, 20'h010, 16'h0, 0, 16'h5A5A, 0, 0);
    tv[16] = v(1, 1, 1, 1, 1, 20'h000, 16'h0, 0, 16'hFFFF, 0, 0);
    tv[17] = v(0, 1, 0, 0, 0, 20'h415, 16'h7777, 1, 16'h7777, 0, 0);
    tv[18] = v(1, 1, 1, 0, 0, 20'h000, 16'h0, 0, 16'hFFFF, 0, 1);
    tv[19] = v(1, 1, 1, 0, 0, 20'h000, 16'h0, 0, 16'hFFFF, 0, 0);
    #2;
    chk("reset_data", Data, 16'hFFFF);
    chk("reset_busy", {15'd0, Busy}, 16'd0);
    chk("reset_err", {15'd0, AddrErr}, 16'd0);
    set_in(1, 1, 1, 1, 1, 0, 0, 0);
    Reset = 0;
    for (int i = 0; i < 1024; i++) set_in(0, 1, 0, 0, 0, 20'(i), 16'h0, 1);
    foreach (tv[i]) begin
      set_in(tv[i].ce, tv[i].oe, tv[i].we, tv[i].ub, tv[i].lb, tv[i].a, tv[i].w, tv[i].d);
      chk($sformatf("vec%0d_data", i), Data, tv[i].ed);
      chk($sformatf("vec%0d_busy", i), {15'd0, Busy}, {15'd0, tv[i].eb});
      chk($sformatf("vec%0d_err", i), {15'd0, AddrErr}, {15'd0, tv[i].ee});
    end
    // Address change while waiting restarts the latency count.
    set_in(0, 1, 0, 0, 0, 20'h011, 16'hC0DE, 1);
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    set_in(0, 0, 1, 0, 0, 20'h011, 16'h0, 0);
    chk("chg_busy0", {15'd0, Busy}, 16'd1);
    chk("chg_data0", Data, 16'hFFFF);
    set_in(0, 0, 1, 0, 0, 20'h011, 16'h0, 0);
    chk("chg_busy1", {15'd0, Busy}, 16'd1);
    chk("chg_data1", Data, 16'hFFFF);
    set_in(0, 0, 1, 0, 0, 20'h011, 16'h0, 0);
    chk("chg_data2", Data, 16'hC0DE);
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    chk("chg_drive_z", Data, 16'hFFFF);
    // Reset mid-drive, writes ignored during reset, fresh request afterwards.
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    chk("rst_pre_data", Data, 16'h5A5A);
    Reset = 1;
    #1;
    chk("rst_mid_data", Data, 16'hFFFF);
    chk("rst_mid_busy", {15'd0, Busy}, 16'd0);
    set_in(0, 1, 0, 0, 0, 20'h010, 16'h0000, 1);
    set_in(0, 1, 0, 0, 0, 20'h010, 16'h0000, 1);
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    Reset = 0;
    chk("rst_rel_busy", {15'd0, Busy}, 16'd0);
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    chk("rst_new_busy", {15'd0, Busy}, 16'd1);
    set_in(0, 0, 1, 0, 0, 20'h010, 16'h0, 0);
    chk("rst_reread", Data, 16'h5A5A);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic ce, oe, we, ub, lb, d;
      logic [19:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) != 0 && rd_m) ? ADDR :
          {($urandom_range(0, 4) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0, 10'($urandom_range(0, 15))};
      ub = $urandom_range(0, 3) == 0;
      lb = $urandom_range(0, 3) == 0;
      ce = r == 7;
      oe = (r == 8 || r < 2) ? 1'b1 : (r == 9) ? 1'b0 : 1'($urandom);
      we = (r < 2 || r == 9) ? 1'b0 : (r == 7) ? 1'($urandom) : 1'b1;
      if (r >= 2 && r <= 6) oe = 0;
      d = !we;
      set_in(ce, oe, we, ub, lb, a, 16'($urandom), d);
      chk("rnd_data", Data, exp_data());
      chk("rnd_busy", {15'd0, Busy}, {15'd0, held && age < LAT});
      chk("rnd_err", {15'd0, AddrErr}, {15'd0, err_m});
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set the word count of the backing store to 2**DEPTH_LOG2 words of 16 bits.
REQ-002 Parameter READ_LAT, default 2, range 1..7, SHALL set the number of rising edges from read request to data on bus.
REQ-003 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 CE, UB, LB, OE, WE  input  1 each  SHALL be active-low chip enable, upper-byte, lower-byte, output-enable and write-enable from the CPU.
REQ-006 ADDR  input  20  SHALL be the word address; only ADDR[DEPTH_LOG2-1:0] SHALL select a word.
REQ-007 Data  inout  16  SHALL be the shared bus: driven only per REQ-013, high-Z otherwise.
REQ-008 Busy  output  1  SHALL be high while a read is pending (state RD_WAIT).
REQ-009 AddrErr  output  1  SHALL pulse high for one cycle when an access is accepted with any of ADDR[19:DEPTH_LOG2] nonzero.

Function
REQ-010 FSM states SHALL be IDLE, RD_WAIT and RD_DRIVE.
REQ-011 Read request = CE=0, OE=0, WE=1. In IDLE, a read request SHALL latch ADDR, load the wait counter with READ_LAT-1 and enter RD_WAIT. If READ_LAT=1, it SHALL enter RD_DRIVE directly.
REQ-012 RD_WAIT SHALL decrement the counter each edge and enter RD_DRIVE when the counter reaches 0, so Data is valid READ_LAT edges after the request edge.
REQ-013 In RD_DRIVE, Data SHALL be driven with the latched word while CE=0, OE=0 and WE=1. Lanes SHALL follow REQ-024/025.
REQ-014 RD_DRIVE SHALL remain while the read request and ADDR are unchanged, and SHALL return to IDLE when the request is withdrawn.
REQ-015 An ADDR change in RD_WAIT or RD_DRIVE, with the request still held, SHALL relatch ADDR, reload the counter and enter RD_WAIT; Data SHALL go high-Z in the same cycle.
REQ-016 Write = CE=0, WE=0. It SHALL commit Data to the addressed word on every rising edge where it holds (level-sensitive), regardless of OE.
REQ-017 WE=0 SHALL take priority over OE: Data SHALL go high-Z combinationally and the FSM SHALL go to IDLE at the next edge.
REQ-018 CE=1 SHALL force Data to high-Z combinationally and the FSM to IDLE at the next edge. No writes SHALL occur while CE=1.
REQ-019 Out-of-range addresses SHALL alias modulo 2**DEPTH_LOG2 and SHALL still complete; only AddrErr flags them.
REQ-020 A read of a word written on the preceding edge SHALL return the new value (write-before-read).

Reset
REQ-021 Reset SHALL immediately force state IDLE, counter 0, Busy=0, AddrErr=0 and Data high-Z, including mid-read.
REQ-022 Reset SHALL NOT alter backing-store contents. Simulation initial contents SHALL be 16'h0000.
REQ-023 Accesses SHALL be ignored while Reset=1. The first request after deassertion SHALL be treated as new.

Configuration
REQ-024 With SRAM_BYTE_LANE_EN defined:
- writes SHALL update only lanes whose strobe is low (UB for [15:8], LB for [7:0]);
- reads SHALL drive only enabled lanes, with disabled lanes high-Z;
- UB=LB=1 SHALL make a write a no-op.
REQ-025 Without SRAM_BYTE_LANE_EN, UB and LB SHALL be ignored and every access SHALL be a full 16-bit word.

Verification
REQ-026 Write 16'hBEEF to ADDR 20'h00010 (CE=0, WE=0, one edge), then read with READ_LAT=2 -> Data=16'hBEEF exactly 2 edges after request; Busy high for 1 cycle.
REQ-027 Read pending in RD_WAIT, ADDR changes 20'h10 -> 20'h11 -> counter reloads; Data high-Z until 2 edges after the change, then shows word 20'h11.
REQ-028 In RD_DRIVE, assert Reset -> Data high-Z and Busy=0 in the same cycle; after release, a reread of 20'h10 returns 16'hBEEF.
REQ-029 Access with ADDR=20'h00410 (DEPTH_LOG2=10) -> AddrErr one-cycle pulse; aliases to word 20'h010.
REQ-030 SRAM_BYTE_LANE_EN defined: word=16'hBEEF, write 16'h1234 with UB=1, LB=0 -> readback 16'hBE34. Undefined: same stimulus -> 16'h1234.
REQ-031 OE=0 and WE=0 together with Data forced to 16'h5A5A -> no bus contention (responder high-Z), word updated to 16'h5A5A.
